enc_bundler: RTL and testbench
==============================

ENC_BUNDLER -- requirements
Module: enc_bundler

Interface
REQ-001 SHALL have parameter HV_DIM, default 1024, hypervector width in bits.
REQ-002 SHALL have parameter FEATURES_PER_CC, default 62; each beat carries FEATURES_PER_CC/2 bound vectors.
REQ-003 SHALL have parameter NUM_BEATS, default 20, beats bundled per query.
REQ-004 SHALL have parameter CNT_W, default 10, per-dimension counter width.
REQ-005 SHALL have parameter THRESHOLD, default 8, minimum count for a set output bit.
REQ-006 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-007 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start_encoding  input  1  one-cycle pulse; clears counters and begins a query.
REQ-009 SHALL have port hv_valid  input  1  beat present on shifted_hv.
REQ-010 SHALL have port shifted_hv  input  HV_DIM x (FEATURES_PER_CC/2)  bound vectors, one beat.
REQ-011 SHALL have port hv_ready  output  1  beat accepted when hv_valid && hv_ready.
REQ-012 SHALL have port query_hv  output  HV_DIM  bundled, thresholded query vector.
REQ-013 SHALL have port query_valid  output  1  query_hv valid.
REQ-014 SHALL have port query_ready  input  1  consumer accepts query_hv.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, THRESH, DONE.
REQ-017 IDLE: hv_ready=0; start_encoding -> clear all counters and beat counter, go to ACCUM next cycle.
REQ-018 ACCUM: hv_ready=1; per accepted beat, counter[d] += popcount over i of shifted_hv[i][d], for every d.
REQ-019 Counter add SHALL saturate at 2^CNT_W-1; no wrap.
REQ-020 Beat counter SHALL increment per accepted beat; on accepting beat NUM_BEATS-1, go to THRESH.
REQ-021 hv_valid=0 in ACCUM SHALL stall without counter change.
REQ-022 THRESH: hv_ready=0; register query_hv[d] = (counter[d] >= THRESHOLD) in one cycle, go to DONE.
REQ-023 DONE: query_valid=1, query_hv held stable until query_valid && query_ready; then IDLE next cycle.
REQ-024 Latency: query_valid SHALL assert exactly 2 cycles after the final beat handshake.
REQ-025 start_encoding in ACCUM, THRESH or DONE SHALL abort: counters cleared, query_valid dropped, state ACCUM next cycle; a beat coincident with the abort is discarded.
REQ-026 hv_valid outside ACCUM SHALL be ignored.
REQ-027 THRESHOLD=0 SHALL yield all-ones query_hv; THRESHOLD > 2^CNT_W-1 SHALL yield all-zero.

Reset
REQ-028 nrst low SHALL immediately force state IDLE, counters 0, beat counter 0, query_hv 0, query_valid 0, hv_ready 0, busy 0.
REQ-029 Reset assertion mid-query SHALL discard all partial accumulation; the first query after release requires a new start_encoding.

Verification
REQ-030 All-zero beats x20, THRESHOLD=8 -> query_hv all zero, query_valid 2 cycles after beat 20.
REQ-031 Beats where bit 5 set in all 31 vectors, bit 6 set in 1 vector per beat x20 -> counter[5]=620, counter[6]=20; query_hv bit 5 and bit 6 set, others 0.
REQ-032 Bit 7 set in all vectors, CNT_W=9 -> counter[7] saturates at 511, no wrap; query_hv[7]=1.
REQ-033 hv_valid toggling 1/0 with query_ready low 5 cycles -> exactly 20 beats counted; query_hv stable, query_valid held during backpressure.
REQ-034 start_encoding after beat 10, then 20 all-zero beats -> query_hv all zero (earlier counts discarded).
REQ-035 nrst pulsed low during ACCUM -> all outputs 0 asynchronously; hv_ready stays 0 until next start_encoding.

Source files
------------

// File: rtl/enc_bundler.sv
// Hypervector bundler: accumulates NUM_BEATS beats of bound vectors into
// saturating per-dimension counters, then thresholds them into one query vector.
//
// state  | meaning
// IDLE   | waiting for start_encoding
// ACCUM  | accepting beats, counting set bits per dimension
// THRESH | comparing counters to THRESHOLD into query_hv
// DONE   | query_hv offered until the consumer takes it
module enc_bundler #(
  parameter int HV_DIM          = 1024,
  parameter int FEATURES_PER_CC = 62,
  parameter int NUM_BEATS       = 20,
  parameter int CNT_W           = 10,
  parameter int THRESHOLD       = 8
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   start_encoding,
  input  logic                                   hv_valid,
  input  logic [HV_DIM*(FEATURES_PER_CC/2)-1:0]  shifted_hv,
  output logic                                   hv_ready,
  output logic [HV_DIM-1:0]                      query_hv,
  output logic                                   query_valid,
  input  logic                                   query_ready,
  output logic                                   busy
);
  localparam int NV     = FEATURES_PER_CC / 2;
  localparam int PC_W   = $clog2(NV + 1);
  localparam int SUM_W  = CNT_W + PC_W;
  localparam int BEAT_W = $clog2(NUM_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  // A threshold above the saturation value can never be met.
  localparam bit THR_UNREACH = THRESHOLD > ((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0] THR_C = THR_UNREACH ? '0 : CNT_W'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} state_t;

  state_t                         state_q, state_d;
  logic [HV_DIM-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [HV_DIM-1:0]              query_hv_q, query_hv_d;
  logic                           hv_ready_q, hv_ready_d;
  logic                           query_valid_q, query_valid_d;
  logic                           busy_q, busy_d;
  logic [HV_DIM-1:0][PC_W-1:0]    pc;
  logic                           accept;

  assign accept = hv_valid && hv_ready_q;

  always_comb begin
    for (int d = 0; d < HV_DIM; d++) begin
      pc[d] = '0;
      for (int i = 0; i < NV; i++) begin
        pc[d] = pc[d] + PC_W'(shifted_hv[i*HV_DIM + d]);
      end
    end
  end

  always_comb begin
    logic [SUM_W-1:0] sum;
    sum           = '0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    beat_d        = beat_q;
    query_hv_d    = query_hv_q;
    query_valid_d = query_valid_q;
    if (start_encoding) begin
      state_d       = ACCUM;
      cnt_d         = '0;
      beat_d        = '0;
      query_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            for (int d = 0; d < HV_DIM; d++) begin
              sum = SUM_W'(cnt_q[d]) + SUM_W'(pc[d]);
              cnt_d[d] = (sum[SUM_W-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
            end
            beat_d = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) state_d = THRESH;
          end
        end
        THRESH: begin
          for (int d = 0; d < HV_DIM; d++) begin
            query_hv_d[d] = !THR_UNREACH && (cnt_q[d] >= THR_C);
          end
          query_valid_d = 1'b1;
          state_d       = DONE;
        end
        DONE: begin
          if (query_ready) begin
            query_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
        default: ;
      endcase
    end
    hv_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      beat_q        <= '0;
      query_hv_q    <= '0;
      hv_ready_q    <= 1'b0;
      query_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beat_q        <= beat_d;
      query_hv_q    <= query_hv_d;
      hv_ready_q    <= hv_ready_d;
      query_valid_q <= query_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign hv_ready    = hv_ready_q;
  assign query_hv    = query_hv_q;
  assign query_valid = query_valid_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_enc_bundler.sv
// Bench for enc_bundler: four instances (default, CNT_W=9, THRESHOLD=0,
// THRESHOLD=1024) share stimulus and are checked against a counting model.
module tb_enc_bundler;
  localparam int HV = 1024;
  localparam int NV = 31;

  logic clk = 1'b0;
  logic nrst, start_encoding, hv_valid, query_ready;
  logic [HV*NV-1:0] hv_bus;
  logic [3:0] rdy_v, qv_v, busy_v;
  logic [HV-1:0] q0, q1, q2, q3;

  enc_bundler #(.CNT_W(10), .THRESHOLD(8)) u_def (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .hv_valid(hv_valid),
    .shifted_hv(hv_bus), .hv_ready(rdy_v[0]), .query_hv(q0), .query_valid(qv_v[0]),
    .query_ready(query_ready), .busy(busy_v[0]));
  enc_bundler #(.CNT_W(9)) u_s9 (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .hv_valid(hv_valid),
    .shifted_hv(hv_bus), .hv_ready(rdy_v[1]), .query_hv(q1), .query_valid(qv_v[1]),
    .query_ready(query_ready), .busy(busy_v[1]));
  enc_bundler #(.THRESHOLD(0)) u_z (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .hv_valid(hv_valid),
    .shifted_hv(hv_bus), .hv_ready(rdy_v[2]), .query_hv(q2), .query_valid(qv_v[2]),
    .query_ready(query_ready), .busy(busy_v[2]));
  enc_bundler #(.THRESHOLD(1024)) u_h (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding), .hv_valid(hv_valid),
    .shifted_hv(hv_bus), .hv_ready(rdy_v[3]), .query_hv(q3), .query_valid(qv_v[3]),
    .query_ready(query_ready), .busy(busy_v[3]));

  always #5 clk = ~clk;

  typedef struct {
    int dim;
    int nvec;
    int nbeats;
    int exp_def;
    int exp_s9;
  } rec_t;

  rec_t tab[8];
  int   cnt[HV];
  int   total = 0;
  int   bad = 0;

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [HV-1:0] act, input logic [HV-1:0] exp);
    int fd = -1;
    int n = 0;
    total++;
    if (act !== exp) begin
      bad++;
      for (int d = 0; d < HV; d++) begin
        if (act[d] !== exp[d]) begin
          n++;
          if (fd < 0) fd = d;
        end
      end
      $display("FAIL %s: bit %0d got %b want %b, %0d bits differ", nm, fd, act[fd], exp[fd], n);
    end
  endtask

  // Expected query: saturated count compared against the threshold.
  function automatic logic [HV-1:0] exp_q(input int cw, input int thr);
    logic [HV-1:0] e;
    int mx = (1 << cw) - 1;
    for (int d = 0; d < HV; d++) e[d] = ((cnt[d] > mx ? mx : cnt[d]) >= thr);
    return e;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < HV; d++) cnt[d] = 0;
  endtask

  task automatic model_add();
    for (int i = 0; i < NV; i++)
      for (int d = 0; d < HV; d++)
        if (hv_bus[i*HV + d]) cnt[d]++;
  endtask

  task automatic gen_beat(input int kind, input int b);
    hv_bus = '0;
    case (kind)
      1: foreach (tab[r])
           if (b < tab[r].nbeats)
             for (int v = 0; v < tab[r].nvec; v++) hv_bus[v*HV + tab[r].dim] = 1'b1;
      2: for (int k = 0; k < HV*NV; k++) hv_bus[k] = ($urandom_range(127) == 0);
      3: hv_bus = '1;
      default: ;
    endcase
  endtask

  task automatic check_queries(input string tag);
    chk_vec({tag, "_q_def"}, q0, exp_q(10, 8));
    chk_vec({tag, "_q_s9"},  q1, exp_q(9, 8));
    chk_vec({tag, "_q_z"},   q2, exp_q(10, 0));
    chk_vec({tag, "_q_h"},   q3, exp_q(10, 1024));
  endtask

  task automatic start_query(input bit coincide);
    start_encoding = 1'b1;
    if (coincide) begin
      gen_beat(3, 0);
      hv_valid = 1'b1;
    end
    clear_model();
    @(posedge clk); #1;
    start_encoding = 1'b0;
    hv_valid = 1'b0;
    chk_int("start_ready", int'(rdy_v), 15);
    chk_int("start_busy", int'(busy_v), 15);
    chk_int("start_qv", int'(qv_v), 0);
  endtask

  // mode 0: valid every cycle, 1: alternating, 2: random
  task automatic run_beats(input int kind, input int n, input int mode);
    int acc = 0;
    int cyc = 0;
    bit hs;
    while (acc < n && cyc < 500) begin
      gen_beat(kind, acc);
      hv_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
      hs = hv_valid && rdy_v[0];
      @(posedge clk); #1;
      if (hs) begin
        model_add();
        acc++;
      end
      cyc++;
    end
    hv_valid = 1'b0;
    if (acc < n) chk_int("beat_budget", acc, n);
  endtask

  task automatic expect_done(input string tag);
    chk_int({tag, "_lat_thresh_qv"}, int'(qv_v), 0);
    chk_int({tag, "_lat_thresh_rdy"}, int'(rdy_v), 0);
    @(posedge clk); #1;
    chk_int({tag, "_lat_done_qv"}, int'(qv_v), 15);
    check_queries(tag);
  endtask

  task automatic finish_query(input int hold);
    query_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      gen_beat(3, 0);
      hv_valid = 1'b1;
      @(posedge clk); #1;
      chk_int("hold_qv", int'(qv_v), 15);
      chk_vec("hold_q", q0, exp_q(10, 8));
    end
    hv_valid = 1'b0;
    query_ready = 1'b1;
    @(posedge clk); #1;
    query_ready = 1'b0;
    chk_int("release_qv", int'(qv_v), 0);
    chk_int("release_busy", int'(busy_v), 0);
    chk_int("release_rdy", int'(rdy_v), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tab[0] = '{5, 31, 20, 1, 1};
    tab[1] = '{6, 1, 20, 1, 1};
    tab[2] = '{7, 31, 20, 1, 1};
    tab[3] = '{9, 27, 19, 1, 1};
    tab[4] = '{10, 7, 1, 0, 0};
    tab[5] = '{11, 8, 1, 1, 1};
    tab[6] = '{12, 4, 2, 1, 1};
    tab[7] = '{13, 0, 0, 0, 0};

    nrst = 1'b1; start_encoding = 1'b0; hv_valid = 1'b0; query_ready = 1'b0; hv_bus = '0;
    clear_model();
    #2 nrst = 1'b0;
    #1;
    chk_int("reset_rdy", int'(rdy_v), 0);
    chk_int("reset_qv", int'(qv_v), 0);
    chk_int("reset_busy", int'(busy_v), 0);
    chk_vec("reset_q", q0, '0);
    @(posedge clk); #1;
    nrst = 1'b1;
    gen_beat(3, 0);
    hv_valid = 1'b1;
    @(posedge clk); #1;
    chk_int("idle_ignore_rdy", int'(rdy_v), 0);
    chk_int("idle_ignore_busy", int'(busy_v), 0);
    hv_valid = 1'b0;

    // all-zero beats
    start_query(0);
    run_beats(0, 20, 0);
    expect_done("zero");
    finish_query(0);

    // table-driven dimensions, including saturation and threshold edges
    start_query(0);
    run_beats(1, 20, 0);
    expect_done("tab");
    foreach (tab[r]) begin
      chk_int($sformatf("tab_def_d%0d", tab[r].dim), int'(q0[tab[r].dim]), tab[r].exp_def);
      chk_int($sformatf("tab_s9_d%0d", tab[r].dim), int'(q1[tab[r].dim]), tab[r].exp_s9);
    end
    finish_query(0);

    // reset in the middle of accumulation
    start_query(0);
    run_beats(3, 5, 0);
    #3 nrst = 1'b0;
    #1;
    chk_int("midrst_rdy", int'(rdy_v), 0);
    chk_int("midrst_busy", int'(busy_v), 0);
    chk_int("midrst_qv", int'(qv_v), 0);
    chk_vec("midrst_q_def", q0, '0);
    chk_vec("midrst_q_z", q2, '0);
    @(posedge clk); #1;
    nrst = 1'b1;
    gen_beat(3, 0);
    hv_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_int("postrst_rdy", int'(rdy_v), 0);
      chk_int("postrst_busy", int'(busy_v), 0);
    end
    hv_valid = 1'b0;

    // alternating valid with 5 cycles of consumer backpressure
    start_query(0);
    run_beats(2, 20, 1);
    expect_done("bp");
    finish_query(5);

    // abort during accumulation with a coincident beat that must be dropped
    start_query(0);
    run_beats(3, 10, 0);
    start_query(1);
    run_beats(0, 20, 0);
    expect_done("abort");
    finish_query(0);

    // abort while a query is being offered
    start_query(0);
    run_beats(2, 20, 2);
    expect_done("pre_abort");
    start_query(0);
    run_beats(2, 20, 2);
    expect_done("post_abort");
    finish_query(1);

    // random queries
    for (int q = 0; q < 4; q++) begin
      start_query(0);
      run_beats(2, 20, 2);
      expect_done($sformatf("rnd%0d", q));
      finish_query($urandom_range(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
